// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: forwarding selects plus load-use stall/bubble/flush/freeze sequencing.
// Optional HAZ_STALL_CNT_EN adds saturating ldu_cnt/frz_cnt event counters.
module ex_hazard_ctrl #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [1:0]        fwd_A,
  output logic [1:0]        fwd_B,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              freeze
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0]       ldu_cnt,
  output logic [15:0]       frz_cnt
`endif
);
  typedef enum logic {RUN, LDUSE} state_t;
  state_t state, state_n;
  // The WB slot never feeds a forward select, so only EX and MEM are shadowed.
  logic ex_v, ex_rw, ex_mr, mem_v, mem_rw;
  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic hz, adv;
  logic [1:0] fa, fb;
  function automatic logic hit(input logic v, input logic rw, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] r, input logic u);
    return u && v && rw && (rd == r);
  endfunction
  always_comb begin
    adv = !mem_stall;
    freeze = mem_stall;
    hz = id_valid && ex_mr && (hit(ex_v, ex_rw, ex_rd, id_rs, id_use_rs) ||
                               hit(ex_v, ex_rw, ex_rd, id_rt, id_use_rt));
    stall_id = adv && (state == RUN) && hz && !flush;
    bubble_ex = adv && (stall_id || flush);
    fa[1] = hit(ex_v, ex_rw, ex_rd, id_rs, id_use_rs) && !ex_mr;
    fa[0] = !fa[1] && hit(mem_v, mem_rw, mem_rd, id_rs, id_use_rs);
    fb[1] = hit(ex_v, ex_rw, ex_rd, id_rt, id_use_rt) && !ex_mr;
    fb[0] = !fb[1] && hit(mem_v, mem_rw, mem_rd, id_rt, id_use_rt);
    state_n = !adv ? state : stall_id ? LDUSE : RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? RUN : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_v, ex_rw, ex_mr, ex_rd} <= '0;
      {mem_v, mem_rw, mem_rd} <= '0;
      fwd_A <= 2'b00;
      fwd_B <= 2'b00;
    end else if (adv) begin
      {mem_v, mem_rw, mem_rd} <= {ex_v, ex_rw, ex_rd};
      {ex_v, ex_rw, ex_mr, ex_rd} <= bubble_ex ? '0 : {id_valid, id_regwrite, id_memread, id_rd};
      fwd_A <= bubble_ex ? 2'b00 : fa;
      fwd_B <= bubble_ex ? 2'b00 : fb;
    end
  end
`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ldu_cnt <= '0;
      frz_cnt <= '0;
    end else begin
      if (stall_id && ldu_cnt != 16'hFFFF) ldu_cnt <= ldu_cnt + 16'd1;
      if (freeze && frz_cnt != 16'hFFFF) frz_cnt <= frz_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: random instruction stream vs. an EX-entry history model, scoreboard checked.
module tb_ex_hazard_ctrl;
  localparam int AW = 3;
  logic clk = 0, rst = 1, id_valid = 0, id_use_rs = 0, id_use_rt = 0;
  logic id_regwrite = 0, id_memread = 0, mem_stall = 0, flush = 0;
  logic [AW-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [1:0] fwd_A, fwd_B;
  logic stall_id, bubble_ex, freeze;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] ldu_cnt, frz_cnt;
`endif
  always #5 clk = ~clk;
  ex_hazard_ctrl #(.REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_stall(mem_stall),
    .flush(flush), .fwd_A(fwd_A), .fwd_B(fwd_B), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .freeze(freeze)
`ifdef HAZ_STALL_CNT_EN
    , .ldu_cnt(ldu_cnt), .frz_cnt(frz_cnt)
`endif
  );
  typedef struct {logic v, w, ld, urs, urt; logic [AW-1:0] rd, rs, rt;} ins_t;
  typedef struct {logic s, b, f;} comb_t;
  ins_t hist[$];
  ins_t cur;
  comb_t qc[$];
  logic [3:0] qf[$];
  logic [3:0] fwd_m = 0;
  int total = 0, bad = 0, n_ldu = 0, n_frz = 0;
  // hist holds instructions in the order they entered EX: [$] is EX, [$-1] is MEM.
  function automatic logic writes(input int age, input logic [AW-1:0] r);
    int k;
    if (hist.size() <= age) return 1'b0;
    k = hist.size() - 1 - age;
    return hist[k].v && hist[k].w && hist[k].rd == r;
  endfunction
  function automatic logic ex_load();
    return hist.size() > 0 && hist[hist.size()-1].v && hist[hist.size()-1].ld;
  endfunction
  function automatic logic [1:0] src(input logic u, input logic [AW-1:0] r);
    if (!u) return 2'd0;
    if (writes(0, r) && !ex_load()) return 2'd2;
    return writes(1, r) ? 2'd1 : 2'd0;
  endfunction
  function automatic ins_t rnd();
    ins_t i;
    i.v = $urandom_range(0, 7) != 0;
    i.ld = i.v && $urandom_range(0, 2) == 0;
    i.w = i.v && (i.ld || $urandom_range(0, 3) != 0);
    i.urs = i.v && $urandom_range(0, 3) != 0;
    i.urt = i.v && $urandom_range(0, 1) != 0;
    i.rd = AW'($urandom_range(0, 3));
    i.rs = AW'($urandom_range(0, 3));
    i.rt = AW'($urandom_range(0, 3));
    return i;
  endfunction
  task automatic step(input logic r, input logic ms, input logic fl);
    comb_t e;
    ins_t nx;
    logic hz, st;
    @(negedge clk);
    rst = r; mem_stall = ms; flush = fl;
    id_valid = cur.v; id_regwrite = cur.w; id_memread = cur.ld; id_rd = cur.rd;
    id_rs = cur.rs; id_rt = cur.rt; id_use_rs = cur.urs; id_use_rt = cur.urt;
    #1;
    hz = cur.v && ex_load() && ((cur.urs && writes(0, cur.rs)) || (cur.urt && writes(0, cur.rt)));
    st = !ms && hz && !fl;
    if (!r) begin
      e.s = st; e.b = !ms && (st || fl); e.f = ms;
      qc.push_back(e);
    end
    if (r) begin
      hist.delete(); fwd_m = 0; n_ldu = 0; n_frz = 0;
    end else begin
      n_ldu += int'(st); n_frz += int'(ms);
      if (!ms) begin
        fwd_m = (st || fl) ? 4'd0 : {src(cur.urs, cur.rs), src(cur.urt, cur.rt)};
        nx = cur;
        if (st || fl) nx.v = 1'b0;
        hist.push_back(nx);
        if (hist.size() > 2) void'(hist.pop_front());
      end
    end
    qf.push_back(fwd_m);
    if (r || (!ms && !st)) cur = rnd();
  endtask
  initial forever begin
    comb_t e;
    @(negedge clk); #2;
    if (qc.size() > 0) begin
      e = qc.pop_front();
      total++;
      if ({stall_id, bubble_ex, freeze} !== {e.s, e.b, e.f}) begin
        bad++;
        $display("FAIL comb stall/bubble/freeze got %b%b%b want %b%b%b at %0t",
                 stall_id, bubble_ex, freeze, e.s, e.b, e.f, $time);
      end
    end
  end
  initial forever begin
    logic [3:0] f;
    @(posedge clk); #1;
    if (qf.size() > 0) begin
      f = qf.pop_front();
      total++;
      if ({fwd_A, fwd_B} !== f) begin
        bad++;
        $display("FAIL fwd A/B got %b/%b want %b/%b at %0t", fwd_A, fwd_B, f[3:2], f[1:0], $time);
      end
    end
  end
  initial begin
    int burst;
    logic pf, pm, fl, ms, r;
    burst = 0; pf = 0; pm = 0;
    cur = rnd();
    step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      r = (i % 997) == 500;
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 4);
      ms = burst > 0;
      if (burst > 0) burst--;
      fl = (pf && pm) ? 1'b1 : ($urandom_range(0, 7) == 0);
      step(r, ms, fl);
      pf = fl; pm = ms;
    end
    @(posedge clk); #2;
`ifdef HAZ_STALL_CNT_EN
    total++;
    if (ldu_cnt !== 16'(n_ldu)) begin
      bad++;
      $display("FAIL ldu_cnt got %0d want %0d", ldu_cnt, n_ldu);
    end
    total++;
    if (frz_cnt !== 16'(n_frz)) begin
      bad++;
      $display("FAIL frz_cnt got %0d want %0d", frz_cnt, n_frz);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the five-stage core. It owns the forwarding selects `fwd_A`/`fwd_B` consumed by the execute stage, and the load-use stall, bubble and flush sequencing around it. It keeps its own shadow of the EX/MEM/WB destination-register state, so it needs only decode-stage register information plus the memory-busy and branch-flush signals. It sits beside the ID/EX pipeline register and drives the execute stage's forwarding muxes.

## Interface
Parameters:
- `REG_AW`, default 3: register-address width (8 GPRs; R0 is an ordinary register).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_AW  source register addresses of the ID instruction.
- `id_use_rs`, `id_use_rt`  in  1  the ID instruction reads rs / rt.
- `id_rd`  in  REG_AW  destination register of the ID instruction.
- `id_regwrite`  in  1  the ID instruction writes `id_rd`.
- `id_memread`  in  1  the ID instruction is a load.
- `mem_stall`  in  1  data memory busy; the whole pipeline freezes.
- `flush`  in  1  branch/jump taken in EX; discard the IF and ID instructions.
- `fwd_A`, `fwd_B`  out  2  EX operand selects: bit1 = EX/MEM data, bit0 = MEM/WB data, 00 = register file. Bit1 has priority; the block never drives 11.
- `stall_id`  out  1  hold PC and IF/ID this cycle.
- `bubble_ex`  out  1  load a NOP into ID/EX this cycle.
- `freeze`  out  1  hold every pipeline register this cycle.

## Operation
- Shadow slots EX, MEM and WB. Each slot holds {valid, regwrite, memread, rd}. Reset clears every slot to invalid.
- Advance is the condition `!freeze`. On advance:
  - WB←MEM and MEM←EX.
  - EX←ID, unless `bubble_ex` is set, in which case EX←invalid.
- Match rule: slot S hits source r when S.valid & S.regwrite & (S.rd == r) and the corresponding `id_use_*` is set.
- Load-use hazard: `id_valid` & EX.memread & EX hits rs or rt.
- FSM states: RUN and LDUSE.
  - RUN to LDUSE: advance & load-use hazard & !flush.
  - LDUSE to RUN: the next advance cycle, unconditionally.
  - Freeze holds the current state.
- `stall_id` = !freeze & load-use hazard & !flush. Combinational; asserted in the RUN cycle that detects the hazard.
- `bubble_ex` = !freeze & (`stall_id` | `flush`).
- Forward computation, registered into `fwd_A`/`fwd_B` on advance and only when ID really moves into EX (`!bubble_ex`):
  - bit1 = the EX slot hits the source and is not a load.
  - bit0 = !bit1 & the MEM slot hits the source.
  - When ID does not move into EX (`bubble_ex`), `fwd_*` load 00.
- After a load-use bubble, the load sits in the MEM slot, so the consumer enters EX with bit0 set (MEM/WB forward).
- Flush: has priority over load-use. The ID instruction is dropped (EX←invalid, `fwd_*`←00). The FSM stays in or returns to RUN.
- Flush is ignored while `freeze` is high. EX holds the branch during a freeze, so the source keeps `flush` asserted until the freeze ends.
- `freeze` = `mem_stall`, combinational passthrough. While it is high, no slot, FSM or `fwd_*` register changes.

## Timing
- Reset values: `fwd_A`=`fwd_B`=00, FSM=RUN, all slots invalid. `stall_id`=`bubble_ex`=0 unless `flush`; `freeze` follows `mem_stall`.
- `fwd_*`: registered, so they are valid for the whole cycle in which the consumer is in EX. Latency is one cycle from ID.
- `stall_id`, `bubble_ex`, `freeze`: combinational in the same cycle, with no register in the path from `id_*`, `flush` or `mem_stall`.
- Load-use costs exactly one bubble cycle. Back-to-back loads feeding a consumer cost one bubble per dependent pair.
- `mem_stall` asserted mid-LDUSE: the freeze extends, and the bubble is inserted on the first advance cycle.
- Reset asserted mid-stall: the next cycle is the RUN/invalid state regardless of inputs.

## Configuration
- `HAZ_STALL_CNT_EN` defined:
  - Adds outputs `ldu_cnt[15:0]` and `frz_cnt[15:0]`, with reset value 0.
  - `ldu_cnt` increments on each cycle `stall_id` is high; `frz_cnt` increments on each cycle `freeze` is high.
  - Both saturate at 16'hFFFF.
- `HAZ_STALL_CNT_EN` undefined: the ports and counters are absent and the behaviour is otherwise identical.

## Test plan
- ALU R1←…, then a consumer of R1 in the next cycle: the consumer's EX cycle shows `fwd_A`=10. With one unrelated instruction between producer and consumer: `fwd_A`=01.
- LD R2, then ADD reading R2 as rt: one cycle with `stall_id`=1 and `bubble_ex`=1, then ADD in EX with `fwd_B`=01. No further stall follows.
- Writers of R3 in both the EX and MEM slots, consumer reads R3: `fwd_A`=10, never 11.
- `mem_stall` held 3 cycles during a pending load-use: `freeze`=1 for 3 cycles, `fwd_*` and FSM unchanged, then exactly one bubble.
- `flush` and load-use asserted in the same cycle: `bubble_ex`=1, `stall_id`=0, next `fwd_*`=00, FSM=RUN.
- `rst` during LDUSE: the next cycle has all outputs at reset values. With `HAZ_STALL_CNT_EN`, counters read 0 after reset and the `ldu_cnt` count matches the number of injected bubbles.
